// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU multiply path: sequencer state encoding,
// packed-width bit positions and the default step bound.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int PW_32 = 4;
    localparam int PW_16 = 3;
    localparam int PW_8  = 2;
    localparam int PW_4  = 1;
    localparam int PW_2  = 0;

    localparam int MUL_MAX_STEPS = 34;

    function automatic logic pw_onehot(input logic [4:0] pw);
        return (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/xc_malu_mul_seq.sv
// Multi-cycle sequencer for the packed multiply step unit: latches a request,
// iterates the external combinational step until it reports ready, returns the result.
module xc_malu_mul_seq
    import xc_malu_pkg::*;
#(
    parameter int MAX_STEPS = MUL_MAX_STEPS
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_pw,
    input  logic        req_lhs_sign,
    input  logic        req_rhs_sign,
    input  logic        req_carryless,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_err,
    output logic [31:0] step_rs1,
    output logic [31:0] step_rs2,
    output logic [5:0]  step_count,
    output logic [63:0] step_acc,
    output logic [31:0] step_arg_0,
    output logic [4:0]  step_pw,
    output logic        step_lhs_sign,
    output logic        step_rhs_sign,
    output logic        step_carryless,
    input  logic [63:0] step_n_acc,
    input  logic [31:0] step_n_arg_0,
    input  logic        step_ready,
    output logic        padd_grant
);

    localparam logic [5:0] CNT_LAST = 6'(MAX_STEPS - 1);

    mul_state_t  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] arg0_q, arg0_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  pw_q, pw_d;
    logic        lsgn_q, lsgn_d;
    logic        rsgn_q, rsgn_d;
    logic        cl_q, cl_d;
    logic [63:0] result_q, result_d;
    logic        err_q, err_d;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= 6'd0;
            acc_q    <= 64'd0;
            arg0_q   <= 32'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            pw_q     <= 5'd0;
            lsgn_q   <= 1'b0;
            rsgn_q   <= 1'b0;
            cl_q     <= 1'b0;
            result_q <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            arg0_q   <= arg0_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            pw_q     <= pw_d;
            lsgn_q   <= lsgn_d;
            rsgn_q   <= rsgn_d;
            cl_q     <= cl_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        arg0_d   = arg0_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        pw_d     = pw_q;
        lsgn_d   = lsgn_q;
        rsgn_d   = rsgn_q;
        cl_d     = cl_q;
        result_d = result_q;
        err_d    = err_q;

        // flush overrides everything, including a request accepted this cycle
        if (flush) begin
            state_d = MUL_IDLE;
            count_d = 6'd0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (req_valid) begin
                        rs1_d   = req_rs1;
                        rs2_d   = req_rs2;
                        pw_d    = req_pw;
                        lsgn_d  = req_lhs_sign;
                        rsgn_d  = req_rhs_sign;
                        cl_d    = req_carryless;
                        acc_d   = 64'd0;
                        arg0_d  = req_rs2;
                        count_d = 6'd0;
                        if (pw_onehot(req_pw)) begin
                            state_d = MUL_RUN;
                        end else begin
                            state_d  = MUL_DONE;
                            result_d = 64'd0;
                            err_d    = 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_d  = step_n_acc;
                    arg0_d = step_n_arg_0;
                    if (step_ready) begin
                        state_d  = MUL_DONE;
                        result_d = step_n_acc;
                        err_d    = 1'b0;
                    end else if (count_q == CNT_LAST) begin
                        state_d  = MUL_DONE;
                        result_d = step_n_acc;
                        err_d    = 1'b1;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
                MUL_DONE: begin
                    if (rsp_ready) begin
                        state_d = MUL_IDLE;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = MUL_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == MUL_IDLE);
    assign rsp_valid      = (state_q == MUL_DONE);
    assign padd_grant     = (state_q == MUL_RUN);
    assign rsp_result     = result_q;
    assign rsp_err        = err_q;

    assign step_rs1       = rs1_q;
    assign step_rs2       = rs2_q;
    assign step_count     = count_q;
    assign step_acc       = acc_q;
    assign step_arg_0     = arg0_q;
    assign step_pw        = pw_q;
    assign step_lhs_sign  = lsgn_q;
    assign step_rhs_sign  = rsgn_q;
    assign step_carryless = cl_q;

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Bench for xc_malu_mul_seq with a behavioural step unit and a result scoreboard.
module tb_xc_malu_mul_seq;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        req_valid, req_ready;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_pw;
    logic        req_lhs_sign, req_rhs_sign, req_carryless;
    logic        flush;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_result;
    logic [31:0] step_rs1, step_rs2, step_arg_0, step_n_arg_0;
    logic [5:0]  step_count;
    logic [63:0] step_acc, step_n_acc;
    logic [4:0]  step_pw;
    logic        step_lhs_sign, step_rhs_sign, step_carryless;
    logic        step_ready, padd_grant;
    logic        stub;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          runs;
    } exp_t;
    exp_t sb[$];

    xc_malu_mul_seq dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pw(req_pw),
        .req_lhs_sign(req_lhs_sign), .req_rhs_sign(req_rhs_sign),
        .req_carryless(req_carryless), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .step_rs1(step_rs1), .step_rs2(step_rs2), .step_count(step_count),
        .step_acc(step_acc), .step_arg_0(step_arg_0), .step_pw(step_pw),
        .step_lhs_sign(step_lhs_sign), .step_rhs_sign(step_rhs_sign),
        .step_carryless(step_carryless), .step_n_acc(step_n_acc),
        .step_n_arg_0(step_n_arg_0), .step_ready(step_ready),
        .padd_grant(padd_grant)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] pw, input logic ls,
                                           input logic rs, input logic cl);
        int w;
        logic [63:0] r, la, lb, p, m2;
        w  = pw[4] ? 32 : pw[3] ? 16 : pw[2] ? 8 : pw[1] ? 4 : 2;
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        r  = 64'd0;
        for (int lane = 0; lane < 32 / w; lane++) begin
            la = (64'(a) >> (lane * w)) & ((64'd1 << w) - 64'd1);
            lb = (64'(b) >> (lane * w)) & ((64'd1 << w) - 64'd1);
            if (!cl && ls && la[w-1]) la = la | ~((64'd1 << w) - 64'd1);
            if (!cl && rs && lb[w-1]) lb = lb | ~((64'd1 << w) - 64'd1);
            if (cl) begin
                p = 64'd0;
                for (int i = 0; i < w; i++)
                    if (lb[i]) p = p ^ (la << i);
            end else begin
                p = la * lb;
            end
            r = r | ((p & m2) << (lane * 2 * w));
        end
        return r;
    endfunction

    // Behavioural step unit: accumulates rs1 each step, lands the true product on the ready step
    int steps_n;
    always_comb begin
        steps_n      = step_pw[4] ? 32 : step_pw[3] ? 16 : step_pw[2] ? 8 : step_pw[1] ? 4 : 2;
        step_ready   = !stub && (int'(step_count) == steps_n - 1);
        step_n_acc   = step_ready ? golden(step_rs1, step_rs2, step_pw, step_lhs_sign,
                                           step_rhs_sign, step_carryless)
                                  : step_acc + 64'(step_rs1);
        step_n_arg_0 = step_arg_0 >> 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] pw,
                          input logic ls, input logic rs, input logic cl,
                          input logic [63:0] exp_res, input logic exp_err,
                          input int exp_runs, input int stall, input string tag);
        exp_t e, got;
        int   runs;
        logic done, stable, excl_bad;
        runs = 0; done = 0; stable = 1; excl_bad = 0;
        @(negedge g_clk);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_rs1 = a; req_rs2 = b; req_pw = pw;
        req_lhs_sign = ls; req_rhs_sign = rs; req_carryless = cl;
        req_valid = 1'b1;
        e.res = exp_res; e.err = exp_err; e.runs = exp_runs;
        sb.push_back(e);
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rsp_valid) begin
                done = 1;
                break;
            end
            if (padd_grant) begin
                runs++;
                if (runs == 1) begin
                    chk({tag, "_first_arg0"}, 64'(step_arg_0), 64'(b));
                    chk({tag, "_first_acc"}, step_acc, 64'd0);
                end
                if (step_rs1 !== a || step_rs2 !== b || step_pw !== pw) stable = 0;
                if (req_ready || rsp_valid) excl_bad = 1;
            end
            @(negedge g_clk);
        end
        chk({tag, "_rsp_seen"}, 64'(done), 64'd1);
        chk({tag, "_operands_stable"}, 64'(stable), 64'd1);
        chk({tag, "_grant_excl"}, 64'(excl_bad), 64'd0);
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_result"}, rsp_result, exp_res);
            chk({tag, "_stall_req_ready"}, 64'(req_ready), 64'd0);
            @(negedge g_clk);
        end
        rsp_ready = 1'b1;
        got.res = rsp_result; got.err = rsp_err; got.runs = runs;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, got.res, e.res);
            chk({tag, "_err"}, 64'(got.err), 64'(e.err));
            chk({tag, "_run_cycles"}, 64'(got.runs), 64'(e.runs));
        end else begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end
        @(posedge g_clk);
        @(negedge g_clk);
        rsp_ready = 1'b0;
        chk({tag, "_back_idle"}, 64'({req_ready, rsp_valid, rsp_err}), 64'b100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        g_reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_pw = '0;
        req_lhs_sign = 1'b0; req_rhs_sign = 1'b0; req_carryless = 1'b0;
        flush = 1'b0; rsp_ready = 1'b0; stub = 1'b0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        chk("reset_outs", 64'({req_ready, rsp_valid, rsp_err, padd_grant}), 64'b1000);
        chk("reset_count", 64'(step_count), 64'd0);
        chk("reset_acc", step_acc, 64'd0);
        g_reset = 1'b0;

        run_op(32'h3, 32'h5, 5'b10000, 0, 0, 0, 64'hF, 0, 32, 0, "umul32");
        run_op(32'hFFFF_FFFF, 32'h2, 5'b10000, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32, 5, "smul32");
        run_op(32'h0003_0003, 32'h0003_0002, 5'b01000, 0, 0, 1,
               64'h0000_0005_0000_0006, 0, 16, 0, "clmul16");

        stub = 1'b1;
        run_op(32'h1, 32'h0, 5'b10000, 0, 0, 0, 64'd34, 1, 34, 0, "timeout");
        stub = 1'b0;
        run_op(32'h0000_1234, 32'h0000_0010, 5'b10000, 0, 0, 0, 64'h1_2340, 0, 32, 0, "after_to");

        @(negedge g_clk);
        req_rs1 = 32'h11; req_rs2 = 32'h22; req_pw = 5'b10000;
        req_lhs_sign = 0; req_rhs_sign = 0; req_carryless = 0;
        req_valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        repeat (9) @(negedge g_clk);
        chk("flush_at_cycle10_count", 64'(step_count), 64'd9);
        flush = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        flush = 1'b0;
        chk("flush_idle", 64'({req_ready, rsp_valid, padd_grant}), 64'b100);
        chk("flush_count", 64'(step_count), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge g_clk);
            if (rsp_valid || padd_grant) seen = 1;
        end
        chk("flush_no_rsp", 64'(seen), 64'd0);
        run_op(32'd7, 32'd9, 5'b10000, 0, 0, 0, 64'd63, 0, 32, 0, "post_flush");

        @(negedge g_clk);
        req_rs1 = 32'h3; req_rs2 = 32'h5; req_pw = 5'b10000;
        req_valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (rsp_valid) seen = 1;
            else @(negedge g_clk);
        end
        chk("rst_done_reached", 64'(seen), 64'd1);
        g_reset = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        chk("rst_done_outs", 64'({req_ready, rsp_valid, rsp_err, padd_grant}), 64'b1000);
        chk("rst_done_acc", step_acc, 64'd0);
        chk("rst_done_rs1", 64'(step_rs1), 64'd0);

        run_op(32'h3, 32'h5, 5'b00011, 0, 0, 0, 64'd0, 1, 0, 0, "illegal_pw");
        run_op(32'h0000_0102, 32'h0000_0304, 5'b00100, 0, 0, 0,
               golden(32'h0000_0102, 32'h0000_0304, 5'b00100, 0, 0, 0), 0, 8, 0, "mul8");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
